// File: rtl/ctu_clsp_clkgn_nstep_mc_if.sv
// Config, trigger, LCM and enable signals of the N-step clock-enable generator.
// The master side (CTU / JTAG logic) drives the controls; the generator is the slave.
interface ctu_clsp_clkgn_nstep_mc_if #(
  parameter int NDOM  = 3,
  parameter int CNT_W = 8,
  parameter int LCM_W = 14
);
  logic             cfg_ld;
  logic [NDOM-1:0]  cfg_dom;
  logic [CNT_W-1:0] cfg_cnt;
  logic [1:0]       cfg_mode;
  logic             trigger;
  logic [LCM_W-1:0] lcm_div;
  logic             lcm_restart;
  logic             force_cken;
  logic             testmode_l;
  logic             coin_edge;
  logic [NDOM-1:0]  nstep_sel;
  logic [NDOM-1:0]  nstep_busy;
  logic [NDOM-1:0]  nstep_done;

  modport master (
    output cfg_ld, cfg_dom, cfg_cnt, cfg_mode, trigger, lcm_div,
           lcm_restart, force_cken, testmode_l,
    input  coin_edge, nstep_sel, nstep_busy, nstep_done
  );

  modport slave (
    input  cfg_ld, cfg_dom, cfg_cnt, cfg_mode, trigger, lcm_div,
           lcm_restart, force_cken, testmode_l,
    output coin_edge, nstep_sel, nstep_busy, nstep_done
  );
endinterface

// File: rtl/ctu_clsp_clkgn_nstep_mc.sv
// Multi-domain N-step clock-enable generator: one shared trigger starts every armed
// domain on a common coincident edge, so step sequences repeat exactly run to run.
module ctu_clsp_clkgn_nstep_mc #(
  parameter int NDOM  = 3,
  parameter int CNT_W = 8,
  parameter int LCM_W = 14
) (
  input  logic                      clk,
  input  logic                      io_pwron_rst,
  ctu_clsp_clkgn_nstep_mc_if.slave  bus
);

  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_OFF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Trigger synchronizer and rising-edge one-shot
  // ---------------------------------------------------------------------------
  logic r_trig_meta;
  logic r_trig_sync;
  logic r_trig_dly;
  logic w_trig_1sht;

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the sync chain.
  always_ff @(posedge clk or posedge io_pwron_rst) begin
    if (io_pwron_rst) begin
      r_trig_meta <= 1'b0;
      r_trig_sync <= 1'b0;
      r_trig_dly  <= 1'b0;
    end else begin
      r_trig_meta <= bus.trigger;
      r_trig_sync <= r_trig_meta;
      r_trig_dly  <= r_trig_sync;
    end
  end

  assign w_trig_1sht = r_trig_sync & ~r_trig_dly;

  // ---------------------------------------------------------------------------
  // Coincident-edge (LCM) down-counter
  // ---------------------------------------------------------------------------
  logic [LCM_W-1:0] r_lcm_cnt;
  logic             r_coin_edge;

  always_ff @(posedge clk or posedge io_pwron_rst) begin
    if (io_pwron_rst) begin
      r_lcm_cnt   <= '0;
      r_coin_edge <= 1'b0;
    end else begin
      if (bus.lcm_restart || (r_lcm_cnt <= LCM_W'(1))) begin
        r_lcm_cnt <= bus.lcm_div;
      end else begin
        r_lcm_cnt <= r_lcm_cnt - LCM_W'(1);
      end
      // A divider of 0 parks the counter at 0, so it must still mark every cycle.
      r_coin_edge <= (r_lcm_cnt == LCM_W'(1)) ||
                     ((r_lcm_cnt == '0) && (bus.lcm_div <= LCM_W'(1)));
    end
  end

  // ---------------------------------------------------------------------------
  // Per-domain sequencers
  // ---------------------------------------------------------------------------
  state_e           r_state      [NDOM];
  state_e           w_state_nx   [NDOM];
  logic [CNT_W-1:0] r_cnt        [NDOM];
  logic [CNT_W-1:0] w_cnt_nx     [NDOM];
  logic [CNT_W-1:0] r_cfg_cnt    [NDOM];
  logic [CNT_W-1:0] w_cfg_cnt_nx [NDOM];
  logic [1:0]       r_cfg_mode   [NDOM];
  logic [1:0]       w_cfg_mode_nx[NDOM];
  logic [NDOM-1:0]  r_sel;
  logic [NDOM-1:0]  w_sel_nx;
  logic [NDOM-1:0]  r_done;
  logic [NDOM-1:0]  w_done_nx;
  logic [NDOM-1:0]  r_stop;
  logic [NDOM-1:0]  w_stop_nx;
  logic [NDOM-1:0]  w_busy;

  always_comb begin
    for (int i = 0; i < NDOM; i++) begin
      // NOTE: every output of this block gets a default before the case statement,
      // so no path leaves a signal unassigned and no latch is inferred.
      w_state_nx[i]    = r_state[i];
      w_cnt_nx[i]      = r_cnt[i];
      w_cfg_cnt_nx[i]  = r_cfg_cnt[i];
      w_cfg_mode_nx[i] = r_cfg_mode[i];
      w_sel_nx[i]      = r_sel[i];
      w_done_nx[i]     = 1'b0;
      w_stop_nx[i]     = r_stop[i];
      w_busy[i]        = (r_state[i] != ST_IDLE);

      // Config is only accepted while idle; a load coinciding with an arming
      // trigger is seen by that same run through the *_nx values.
      if (bus.cfg_ld && bus.cfg_dom[i] && (r_state[i] == ST_IDLE)) begin
        w_cfg_cnt_nx[i]  = bus.cfg_cnt;
        w_cfg_mode_nx[i] = bus.cfg_mode;
      end

      case (r_state[i])
        ST_IDLE: begin
          if (w_trig_1sht && (w_cfg_mode_nx[i] != MODE_OFF)) begin
            if ((w_cfg_mode_nx[i] != MODE_FREE) && (w_cfg_cnt_nx[i] == '0)) begin
              w_done_nx[i] = 1'b1;
            end else begin
              w_state_nx[i] = ST_ARM;
              w_stop_nx[i]  = 1'b0;
            end
          end
        end

        ST_ARM: begin
          if (r_coin_edge) begin
            w_state_nx[i] = ST_RUN;
            w_sel_nx[i]   = 1'b1;
            w_cnt_nx[i]   = r_cfg_cnt[i];
          end
        end

        ST_RUN: begin
          if (r_cfg_mode[i] == MODE_FREE) begin
            if (r_stop[i] && r_coin_edge) begin
              w_state_nx[i] = ST_IDLE;
              w_sel_nx[i]   = 1'b0;
              w_done_nx[i]  = 1'b1;
              w_stop_nx[i]  = 1'b0;
            end else if (w_trig_1sht) begin
              w_stop_nx[i] = 1'b1;
            end
          end else if (r_sel[i]) begin
            // Accounting follows the raw enable so output gating never shortens a run.
            if (r_cnt[i] <= CNT_W'(1)) begin
              w_state_nx[i] = ST_IDLE;
              w_sel_nx[i]   = 1'b0;
              w_done_nx[i]  = 1'b1;
            end else begin
              w_cnt_nx[i] = r_cnt[i] - CNT_W'(1);
            end
          end
        end

        default: begin
          w_state_nx[i] = ST_IDLE;
          w_sel_nx[i]   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge io_pwron_rst) begin
    if (io_pwron_rst) begin
      // NOTE: the config registers are a handful of flops, not a RAM, and must come
      // up as cnt=0 / STEP, so they are reset along with the control state.
      for (int i = 0; i < NDOM; i++) begin
        r_state[i]    <= ST_IDLE;
        r_cnt[i]      <= '0;
        r_cfg_cnt[i]  <= '0;
        r_cfg_mode[i] <= 2'b00;
      end
      r_sel  <= '0;
      r_done <= '0;
      r_stop <= '0;
    end else begin
      for (int i = 0; i < NDOM; i++) begin
        r_state[i]    <= w_state_nx[i];
        r_cnt[i]      <= w_cnt_nx[i];
        r_cfg_cnt[i]  <= w_cfg_cnt_nx[i];
        r_cfg_mode[i] <= w_cfg_mode_nx[i];
      end
      r_sel  <= w_sel_nx;
      r_done <= w_done_nx;
      r_stop <= w_stop_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.coin_edge  = r_coin_edge;
  assign bus.nstep_sel  = r_sel & {NDOM{~bus.force_cken & bus.testmode_l}};
  assign bus.nstep_busy = w_busy;
  assign bus.nstep_done = r_done;

endmodule

// File: tb/tb_ctu_clsp_clkgn_nstep_mc.sv
// Randomised scoreboard bench for the N-step generator: stimulus tasks predict each
// run's busy/sel/done timeline from the coincident-edge schedule; a monitor compares.
module tb_ctu_clsp_clkgn_nstep_mc;
  localparam int NDOM    = 3;
  localparam int CNT_W   = 8;
  localparam int LCM_W   = 14;
  localparam int FOREVER = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctu_clsp_clkgn_nstep_mc_if #(.NDOM(NDOM), .CNT_W(CNT_W), .LCM_W(LCM_W)) bus ();

  ctu_clsp_clkgn_nstep_mc #(.NDOM(NDOM), .CNT_W(CNT_W), .LCM_W(LCM_W)) dut (
    .clk          (clk),
    .io_pwron_rst (rst),
    .bus          (bus)
  );

  // One expected run: cycle numbers count posedges; -1 means "never".
  typedef struct {
    int busy_start;
    int busy_end;
    int sel_start;
    int sel_len;
    int done_cyc;
  } run_t;

  run_t exp_q [NDOM][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int m_cnt   [NDOM];
  int m_mode  [NDOM];        // 0 STEP, 1 FREE, 2 OFF
  int m_arm   [NDOM];
  int m_until [NDOM];        // first idle cycle after the current run
  int m_free_c[NDOM];
  bit m_stop  [NDOM];
  bit gated = 1'b0;
  int anc = 0, per = 6, p_anc = 0, p_per = 6;
  bit p_valid = 1'b0;

  // Monitor observations
  int ob_bs[NDOM], ob_be[NDOM], ob_ss[NDOM], ob_sl[NDOM];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit coin_at(input int n);
    if (n > anc) return ((n - anc) % per) == 0;
    if (p_valid && (n > p_anc)) return ((n - p_anc) % p_per) == 0;
    return 1'b0;
  endfunction

  function automatic int next_coin(input int t);
    int b;
    b = (t > anc) ? t : anc + 1;
    return anc + per * ((b - anc + per - 1) / per);
  endfunction

  function automatic bit idle(input int i, input int n);
    return !((m_arm[i] <= n) && (n < m_until[i]));
  endfunction

  function automatic bit all_idle(input int n);
    for (int i = 0; i < NDOM; i++) if (!idle(i, n)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDOM; i++) begin
      m_cnt[i] = 0; m_mode[i] = 0; m_arm[i] = 0; m_until[i] = 0;
      m_free_c[i] = 0; m_stop[i] = 1'b0;
    end
  endtask

  // Config sampled on edge e is accepted by domains idle during cycle e-1.
  task automatic model_cfg(input logic [NDOM-1:0] mask, input int cnt, input int mode, input int e);
    for (int i = 0; i < NDOM; i++) begin
      if (mask[i] && idle(i, e - 1)) begin
        m_cnt[i]  = cnt;
        m_mode[i] = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
      end
    end
  endtask

  // Trigger one-shot sampled on edge t.
  task automatic model_trig(input int t);
    int c;
    run_t r;
    for (int i = 0; i < NDOM; i++) begin
      if (!idle(i, t - 1)) begin
        if ((m_until[i] == FOREVER) && !m_stop[i] && (t - 1 >= m_free_c[i] + 1)) begin
          c = next_coin(t);
          r.busy_start = m_arm[i];
          r.busy_end   = c;
          r.sel_start  = gated ? -1 : m_free_c[i] + 1;
          r.sel_len    = gated ? 0 : c - m_free_c[i];
          r.done_cyc   = c + 1;
          exp_q[i].push_back(r);
          m_until[i] = c + 1;
          m_stop[i]  = 1'b1;
        end
      end else if (m_mode[i] == 0 && m_cnt[i] == 0) begin
        r = '{busy_start: -1, busy_end: -1, sel_start: -1, sel_len: 0, done_cyc: t};
        exp_q[i].push_back(r);
      end else if (m_mode[i] == 0) begin
        c = next_coin(t);
        r.busy_start = t;
        r.busy_end   = c + m_cnt[i];
        r.sel_start  = gated ? -1 : c + 1;
        r.sel_len    = gated ? 0 : m_cnt[i];
        r.done_cyc   = c + m_cnt[i] + 1;
        exp_q[i].push_back(r);
        m_arm[i]   = t;
        m_until[i] = c + m_cnt[i] + 1;
      end else if (m_mode[i] == 1) begin
        m_arm[i]    = t;
        m_until[i]  = FOREVER;
        m_free_c[i] = next_coin(t);
        m_stop[i]   = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_coin", bus.coin_edge, 0);
      check("rst_sel",  bus.nstep_sel, 0);
      check("rst_busy", bus.nstep_busy, 0);
      check("rst_done", bus.nstep_done, 0);
      for (int i = 0; i < NDOM; i++) begin
        exp_q[i].delete();
        ob_bs[i] = -1; ob_be[i] = -1; ob_ss[i] = -1; ob_sl[i] = 0;
      end
    end else begin
      check("coin_edge", bus.coin_edge, coin_at(cyc));
      for (int i = 0; i < NDOM; i++) begin
        if (bus.nstep_busy[i]) begin
          if (ob_bs[i] < 0) ob_bs[i] = cyc;
          ob_be[i] = cyc;
        end
        if (bus.nstep_sel[i]) begin
          if (ob_ss[i] < 0) ob_ss[i] = cyc;
          ob_sl[i]++;
        end
        if (bus.nstep_done[i]) begin
          check($sformatf("done_expected_d%0d", i), int'(exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) begin
            run_t e;
            e = exp_q[i].pop_front();
            check($sformatf("done_cyc_d%0d", i),   cyc,      e.done_cyc);
            check($sformatf("sel_start_d%0d", i),  ob_ss[i], e.sel_start);
            check($sformatf("sel_len_d%0d", i),    ob_sl[i], e.sel_len);
            check($sformatf("busy_start_d%0d", i), ob_bs[i], e.busy_start);
            check($sformatf("busy_end_d%0d", i),   ob_be[i], e.busy_end);
          end
          ob_bs[i] = -1; ob_be[i] = -1; ob_ss[i] = -1; ob_sl[i] = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all return #1 after a posedge)
  // ---------------------------------------------------------------------------
  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [NDOM-1:0] mask, input int cnt, input int mode);
    bus.cfg_ld   = 1'b1;
    bus.cfg_dom  = mask;
    bus.cfg_cnt  = CNT_W'(cnt);
    bus.cfg_mode = 2'(mode);
    model_cfg(mask, cnt, mode, cyc + 1);
    step_n(1);
    bus.cfg_ld = 1'b0;
  endtask

  // Rising trigger; optionally loads config on the very edge that samples the one-shot.
  task automatic trig_run(input bit with_cfg, input logic [NDOM-1:0] mask,
                          input int cnt, input int mode);
    int t;
    bus.trigger = 1'b1;
    t = cyc + 3;
    step_n(2);
    if (with_cfg) begin
      bus.cfg_ld   = 1'b1;
      bus.cfg_dom  = mask;
      bus.cfg_cnt  = CNT_W'(cnt);
      bus.cfg_mode = 2'(mode);
      model_cfg(mask, cnt, mode, cyc + 1);
    end
    model_trig(t);
    step_n(1);
    bus.cfg_ld = 1'b0;
    step_n(2);
    bus.trigger = 1'b0;
    step_n(3);
  endtask

  task automatic restart_lcm(input int div);
    bus.lcm_div     = LCM_W'(div);
    bus.lcm_restart = 1'b1;
    p_anc = anc; p_per = per; p_valid = 1'b1;
    anc = cyc + 1;
    per = (div < 1) ? 1 : div;
    step_n(1);
    bus.lcm_restart = 1'b0;
    step_n(div + 2);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (all_idle(cyc) && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0) begin
        ok = 1'b1;
        break;
      end
      step_n(1);
    end
    check("wait_idle_in_budget", int'(ok), 1);
    step_n(2);
    for (int i = 0; i < NDOM; i++) begin
      check($sformatf("stray_sel_d%0d", i),  ob_ss[i], -1);
      check($sformatf("stray_busy_d%0d", i), ob_bs[i], -1);
    end
  endtask

  // Stops any free-running domain; idle domains are parked in OFF first so the
  // stop trigger cannot start fresh runs.
  task automatic stop_free();
    for (int a = 0; a < 4; a++) begin
      bit any;
      int wc;
      any = 1'b0;
      wc  = 0;
      for (int i = 0; i < NDOM; i++) begin
        if (m_until[i] == FOREVER && !m_stop[i]) begin
          any = 1'b1;
          if (m_free_c[i] > wc) wc = m_free_c[i];
        end
      end
      if (!any) break;
      while (cyc < wc) step_n(1);
      do_cfg('1, 0, 2);
      trig_run(1'b0, '0, 0, 0);
    end
  endtask

  task automatic release_reset();
    rst = 1'b0;
    anc = cyc + 1;
    per = (int'(bus.lcm_div) < 1) ? 1 : int'(bus.lcm_div);
    p_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int modes[5] = '{0, 0, 1, 2, 3};
    bus.cfg_ld = 1'b0; bus.cfg_dom = '0; bus.cfg_cnt = '0; bus.cfg_mode = 2'b00;
    bus.trigger = 1'b0; bus.lcm_div = LCM_W'(6); bus.lcm_restart = 1'b0;
    bus.force_cken = 1'b0; bus.testmode_l = 1'b1;
    model_reset();
    step_n(3);
    release_reset();
    step_n(12);

    // Single STEP run of 4 on domain 0
    do_cfg(3'b001, 4, 0);
    trig_run(1'b0, '0, 0, 0);
    wait_idle();

    // Three strobes: 2 / 5 / 0, one trigger
    do_cfg(3'b001, 2, 0);
    do_cfg(3'b010, 5, 0);
    do_cfg(3'b100, 0, 0);
    trig_run(1'b0, '0, 0, 0);
    wait_idle();

    // FREE on domain 1 with a 4-cycle LCM
    restart_lcm(4);
    do_cfg(3'b111, 0, 2);
    do_cfg(3'b010, 0, 1);
    trig_run(1'b0, '0, 0, 0);
    step_n(10);
    trig_run(1'b0, '0, 0, 0);
    wait_idle();

    // Gated outputs: accounting and done timing unchanged
    restart_lcm(6);
    do_cfg(3'b111, 0, 2);
    do_cfg(3'b001, 3, 0);
    bus.force_cken = 1'b1; gated = 1'b1;
    trig_run(1'b0, '0, 0, 0);
    wait_idle();
    bus.force_cken = 1'b0; bus.testmode_l = 1'b0;
    trig_run(1'b0, '0, 0, 0);
    wait_idle();
    bus.testmode_l = 1'b1; gated = 1'b0;

    // Config while running is ignored; config on the arming edge is used
    do_cfg(3'b001, 20, 0);
    trig_run(1'b0, '0, 0, 0);
    step_n(3);
    do_cfg(3'b001, 7, 0);
    wait_idle();
    trig_run(1'b0, '0, 0, 0);
    wait_idle();
    trig_run(1'b1, 3'b001, 5, 0);
    wait_idle();

    // LCM divider of 1: coincident edge every cycle
    restart_lcm(1);
    do_cfg(3'b001, 3, 3);
    trig_run(1'b0, '0, 0, 0);
    wait_idle();
    restart_lcm(6);

    // Randomised runs
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) restart_lcm(int'($urandom_range(2, 9)));
      for (int i = 0; i < NDOM; i++) begin
        do_cfg(NDOM'(1 << i), int'($urandom_range(0, 12)), modes[$urandom_range(0, 4)]);
      end
      if ($urandom_range(0, 4) == 0) begin
        gated = 1'b1;
        if ($urandom_range(0, 1) == 0) bus.force_cken = 1'b1;
        else bus.testmode_l = 1'b0;
      end
      trig_run($urandom_range(0, 3) == 0, NDOM'($urandom_range(0, 7)),
               int'($urandom_range(0, 12)), modes[$urandom_range(0, 4)]);
      step_n(int'($urandom_range(1, 8)));
      do_cfg(NDOM'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
             modes[$urandom_range(0, 4)]);
      stop_free();
      wait_idle();
      bus.force_cken = 1'b0; bus.testmode_l = 1'b1; gated = 1'b0;
    end

    // Reset in the middle of a long run
    do_cfg(3'b111, 0, 2);
    do_cfg(3'b001, 200, 0);
    trig_run(1'b0, '0, 0, 0);
    step_n(20);
    rst = 1'b1;
    #1;
    check("midrst_sel",  bus.nstep_sel, 0);
    check("midrst_busy", bus.nstep_busy, 0);
    check("midrst_done", bus.nstep_done, 0);
    check("midrst_coin", bus.coin_edge, 0);
    model_reset();
    step_n(3);
    release_reset();
    step_n(30);
    for (int i = 0; i < NDOM; i++) begin
      check($sformatf("leftover_runs_d%0d", i), exp_q[i].size(), 0);
      check($sformatf("no_sel_after_rst_d%0d", i), ob_ss[i], -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
